// File: rtl/instr_window_buf.sv
// instr_window_buf: in-order instruction window in front of the type-sorting
// issue stage. Each cycle the sorter's used slots are removed, the survivors
// are packed down to slot 0 in program order, and new decoder lanes are
// appended behind them. Slots above the occupancy always read as zero.
// Optional build macro: WINDOW_BYPASS_EN (count slots freed this cycle as
// free when computing in_ready).
module instr_window_buf #(
   parameter int FETCH_WIDTH = 4,
   parameter int IN_WIDTH    = 2
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [IN_WIDTH*24-1:0]          in_instr,
   input  logic [$clog2(IN_WIDTH+1)-1:0]   in_count,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic                            flush,
   output logic [FETCH_WIDTH*24-1:0]       instr_in,
   output logic [FETCH_WIDTH-1:0]          instr_valid,
   input  logic [FETCH_WIDTH-1:0]          instr_used,
   output logic                            win_empty,
   output logic                            win_full
);

   localparam int OCC_W = $clog2(FETCH_WIDTH + 1);

   logic [OCC_W-1:0]          occ_q, occ_d;
   logic [FETCH_WIDTH*24-1:0] slots_q, slots_d;
   logic [FETCH_WIDTH-1:0]    used_eff;
   logic                      accept;
   int                        free_slots;
   int                        kept;

   // Valid mask is a thermometer of the registered occupancy.
   always_comb begin
      for (int i = 0; i < FETCH_WIDTH; i++) begin
         instr_valid[i] = (i < int'(occ_q));
      end
   end

   assign used_eff  = instr_used & instr_valid;
   assign instr_in  = slots_q;
   assign win_empty = (occ_q == '0);
   assign win_full  = (occ_q == OCC_W'(FETCH_WIDTH));

   // Handshake: all-or-nothing acceptance against the free slot count.
   always_comb begin
      free_slots = FETCH_WIDTH - int'(occ_q);
`ifdef WINDOW_BYPASS_EN
      for (int i = 0; i < FETCH_WIDTH; i++) begin
         if (used_eff[i]) free_slots = free_slots + 1;
      end
`endif
      in_ready = !flush && (free_slots >= int'(in_count));
      // Out-of-range lane counts are treated as no request.
      accept   = in_valid && in_ready && (in_count != '0)
                 && (int'(in_count) <= IN_WIDTH);
   end

   // Next window: compact the kept slots, then append accepted lanes.
   always_comb begin
      slots_d = '0;
      kept    = 0;
      occ_d   = '0;
      if (!flush) begin
         for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (instr_valid[i] && !used_eff[i]) begin
               slots_d[kept*24 +: 24] = slots_q[i*24 +: 24];
               kept = kept + 1;
            end
         end
         if (accept) begin
            for (int j = 0; j < IN_WIDTH; j++) begin
               if ((j < int'(in_count)) && ((kept + j) < FETCH_WIDTH)) begin
                  slots_d[(kept+j)*24 +: 24] = in_instr[j*24 +: 24];
               end
            end
         end
         occ_d = OCC_W'(kept + (accept ? int'(in_count) : 0));
      end
   end

   // Window state register; reset and flush both leave an all-zero bus.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ_q   <= '0;
         slots_q <= '0;
      end else begin
         occ_q   <= occ_d;
         slots_q <= slots_d;
      end
   end

   // Flag lane counts beyond the upstream width in simulation.
   always @(posedge clk) begin
      if (!rst && in_valid) assert (int'(in_count) <= IN_WIDTH);
   end

endmodule

// File: tb/tb_instr_window_buf.sv
// Bench for instr_window_buf: directed steps from the test plan followed by
// random traffic, all checked against a queue-based model of the window.
module tb_instr_window_buf;

   localparam int FW = 4;
   localparam int IW = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic [IW*24-1:0] in_instr;
   logic [1:0]    in_count;
   logic          in_valid;
   logic          in_ready;
   logic          flush;
   logic [FW*24-1:0] instr_in;
   logic [FW-1:0] instr_valid;
   logic [FW-1:0] instr_used;
   logic          win_empty;
   logic          win_full;

   int checks = 0;
   int errors = 0;
   logic [23:0] q[$];

   localparam logic [23:0] A = 24'hA0_0001, B = 24'hB0_0002, C = 24'hC0_0003;
   localparam logic [23:0] D = 24'hD0_0004, E = 24'hE0_0005, F = 24'hF0_0006;
   localparam logic [23:0] G = 24'h70_0007;

   instr_window_buf #(.FETCH_WIDTH(FW), .IN_WIDTH(IW)) dut (
      .clk(clk), .rst(rst), .in_instr(in_instr), .in_count(in_count),
      .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
      .instr_in(instr_in), .instr_valid(instr_valid), .instr_used(instr_used),
      .win_empty(win_empty), .win_full(win_full)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outs(input string tag);
      logic [FW*24-1:0] bus;
      logic [FW-1:0]    vm;
      bus = '0;
      vm  = '0;
      for (int i = 0; i < q.size(); i++) begin
         bus[i*24 +: 24] = q[i];
         vm[i] = 1'b1;
      end
      chk({tag, "_valid"}, 128'(instr_valid), 128'(vm));
      chk({tag, "_bus"},   128'(instr_in),    128'(bus));
      chk({tag, "_empty"}, 128'(win_empty),   128'(q.size() == 0));
      chk({tag, "_full"},  128'(win_full),    128'(q.size() == FW));
   endtask

   // One clock of stimulus: check in_ready, advance the model, check outputs.
   task automatic step(input string tag, input logic f, input logic v, input logic [1:0] c,
                       input logic [47:0] lanes, input logic [3:0] u);
      logic        rdy;
      int          free;
      logic [23:0] nq[$];
      flush = f; in_valid = v; in_count = c; in_instr = lanes; instr_used = u;
      #1;
      free = FW - q.size();
`ifdef WINDOW_BYPASS_EN
      for (int i = 0; i < q.size(); i++) if (u[i]) free++;
`endif
      rdy = !f && (free >= int'(c));
      chk({tag, "_in_ready"}, 128'(in_ready), 128'(rdy));
      nq = {};
      if (!f) begin
         for (int i = 0; i < q.size(); i++) if (!u[i]) nq.push_back(q[i]);
         if (v && rdy && c != 0)
            for (int j = 0; j < int'(c); j++) nq.push_back(lanes[j*24 +: 24]);
      end
      @(posedge clk);
      #1;
      q = nq;
      check_outs(tag);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_count = 2'd2;
      in_instr = '0; instr_used = '0;
      #2;
      check_outs("reset");
      chk("reset_in_ready", 128'(in_ready), 128'(1));
      @(posedge clk); #1;
      rst = 1'b0;

      // Idle, then fill with A,B / C,D.
      step("idle", 1'b0, 1'b0, 2'd2, '0, 4'b0000);
      step("fill1", 1'b0, 1'b1, 2'd2, {B, A}, 4'b0000);
      step("fill2", 1'b0, 1'b1, 2'd2, {D, C}, 4'b0000);
      chk("fill_bus", 128'(instr_in), 128'({D, C, B, A}));
      chk("fill_full", 128'(win_full), 128'(1));
      step("full_hold", 1'b0, 1'b1, 2'd1, {24'h0, E}, 4'b0000);
      chk("hold_bus", 128'(instr_in), 128'({D, C, B, A}));

      // Holed consume A,C.
      step("holed", 1'b0, 1'b0, 2'd0, '0, 4'b0101);
      chk("holed_bus", 128'(instr_in), 128'({24'h0, 24'h0, D, B}));
      chk("holed_valid", 128'(instr_valid), 128'(4'b0011));

      // Build A,B,C then use B while appending E.
      step("flush0", 1'b1, 1'b0, 2'd0, '0, 4'b0000);
      step("ab", 1'b0, 1'b1, 2'd2, {B, A}, 4'b0000);
      step("c", 1'b0, 1'b1, 2'd1, {24'h0, C}, 4'b0000);
      step("use_app", 1'b0, 1'b1, 2'd1, {24'h0, E}, 4'b0010);
      chk("use_app_bus", 128'(instr_in), 128'({24'h0, E, C, A}));
      chk("use_app_valid", 128'(instr_valid), 128'(4'b0111));

      // Full-window bubble: free one slot and offer one more.
      step("to_full", 1'b0, 1'b1, 2'd1, {24'h0, F}, 4'b0000);
      step("bubble", 1'b0, 1'b1, 2'd1, {24'h0, G}, 4'b0001);
`ifdef WINDOW_BYPASS_EN
      chk("bubble_bus", 128'(instr_in), 128'({G, F, E, C}));
`else
      chk("bubble_bus", 128'(instr_in), 128'({24'h0, F, E, C}));
`endif

      // Flush with pending input.
      step("flush_pend", 1'b1, 1'b1, 2'd2, {B, A}, 4'b0000);
      chk("flush_bus", 128'(instr_in), 128'(0));

      // Asynchronous reset mid-fill.
      step("refill", 1'b0, 1'b1, 2'd2, {B, A}, 4'b0000);
      in_valid = 1'b0; in_count = 2'd2; instr_used = '0;
      #3 rst = 1'b1;
      #1;
      q = {};
      check_outs("async_rst");
      chk("async_rst_in_ready", 128'(in_ready), 128'(1));
      @(posedge clk); #1;
      rst = 1'b0;

      // Random traffic.
      for (int n = 0; n < 300; n++) begin
         step("rand", ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
              2'($urandom_range(0, 2)), {24'($urandom()), 24'($urandom())},
              4'($urandom()));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
